// File: rtl/aq32_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aq32_bus_pkg
// Brief    : Shared types and helpers for the SRAM-side bus fabric.
// Revision : 1.0
// ============================================================================
package aq32_bus_pkg;

    localparam int SRAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Round-robin pick: a tie goes to the master that was not served last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return ~req[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-master round-robin arbiter with optional grant lock,
//            sharing the sram_ctrl command port.
// Revision : 1.0
// ============================================================================
module sram_arbiter
    import aq32_bus_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wrdata,
    input  logic [3:0]        m0_bytesel,
    input  logic              m0_wren,
    input  logic              m0_strobe,
    input  logic              m0_lock,
    output logic              m0_wait,
    output logic [31:0]       m0_rddata,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wrdata,
    input  logic [3:0]        m1_bytesel,
    input  logic              m1_wren,
    input  logic              m1_strobe,
    input  logic              m1_lock,
    output logic              m1_wait,
    output logic [31:0]       m1_rddata,

    output logic [ADDR_W-1:0] slv_addr,
    output logic [31:0]       slv_wrdata,
    output logic [3:0]        slv_bytesel,
    output logic              slv_wren,
    output logic              slv_strobe,
    input  logic              slv_wait,
    input  logic [31:0]       slv_rddata,

    output logic              protocol_err
);

    arb_state_t r_state;
    logic       r_last;

    logic [1:0] w_req;
    logic       w_pick;
    logic       w_granted;
    logic       w_own_idx;
    logic       w_own_strobe;
    logic       w_own_lock;
    logic       w_other_strobe;

    assign w_req          = {m1_strobe, m0_strobe};
    assign w_pick         = rr_pick(w_req, r_last);
    assign w_granted      = (r_state == GNT0) || (r_state == GNT1);
    assign w_own_idx      = (r_state == GNT1);
    assign w_own_strobe   = w_own_idx ? m1_strobe : m0_strobe;
    assign w_own_lock     = w_own_idx ? m1_lock   : m0_lock;
    assign w_other_strobe = w_own_idx ? m0_strobe : m1_strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_state <= w_pick ? GNT1 : GNT0;
                        r_last  <= w_pick;
                    end
                end
                GNT0, GNT1: begin
                    if (!w_own_strobe) begin
                        r_state <= IDLE;
                    end else if (!slv_wait && !w_own_lock) begin
                        // Completion without lock: hand over directly if the other master waits.
                        if (w_other_strobe) begin
                            r_state <= w_own_idx ? GNT0 : GNT1;
                            r_last  <= ~w_own_idx;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        slv_addr    = '0;
        slv_wrdata  = '0;
        slv_bytesel = '0;
        slv_wren    = 1'b0;
        slv_strobe  = 1'b0;
        case (r_state)
            GNT0: begin
                slv_addr    = m0_addr;
                slv_wrdata  = m0_wrdata;
                slv_bytesel = m0_bytesel;
                slv_wren    = m0_wren;
                slv_strobe  = m0_strobe;
            end
            GNT1: begin
                slv_addr    = m1_addr;
                slv_wrdata  = m1_wrdata;
                slv_bytesel = m1_bytesel;
                slv_wren    = m1_wren;
                slv_strobe  = m1_strobe;
            end
            default: ;
        endcase
    end

    assign m0_wait      = m0_strobe && !((r_state == GNT0) && !slv_wait);
    assign m1_wait      = m1_strobe && !((r_state == GNT1) && !slv_wait);
    assign m0_rddata    = slv_rddata;
    assign m1_rddata    = slv_rddata;
    assign protocol_err = w_granted && !w_own_strobe;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed vector table, alternation sequence and randomized
//            traffic against a behavioural model of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_sram_arbiter;

    localparam int ADDR_W = 17;
    localparam logic [ADDR_W-1:0] A0 = 17'h00010;
    localparam logic [ADDR_W-1:0] A1 = 17'h00020;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m_addr    [2];
    logic [31:0]       m_wrdata  [2];
    logic [3:0]        m_bytesel [2];
    logic              m_wren    [2];
    logic              m_strobe  [2];
    logic              m_lock    [2];
    logic              m0_wait, m1_wait;
    logic [31:0]       m0_rddata, m1_rddata;
    logic [ADDR_W-1:0] slv_addr;
    logic [31:0]       slv_wrdata;
    logic [3:0]        slv_bytesel;
    logic              slv_wren, slv_strobe, slv_wait;
    logic [31:0]       slv_rddata;
    logic              protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m_addr[0]), .m0_wrdata(m_wrdata[0]), .m0_bytesel(m_bytesel[0]),
        .m0_wren(m_wren[0]), .m0_strobe(m_strobe[0]), .m0_lock(m_lock[0]),
        .m0_wait(m0_wait), .m0_rddata(m0_rddata),
        .m1_addr(m_addr[1]), .m1_wrdata(m_wrdata[1]), .m1_bytesel(m_bytesel[1]),
        .m1_wren(m_wren[1]), .m1_strobe(m_strobe[1]), .m1_lock(m_lock[1]),
        .m1_wait(m1_wait), .m1_rddata(m1_rddata),
        .slv_addr(slv_addr), .slv_wrdata(slv_wrdata), .slv_bytesel(slv_bytesel),
        .slv_wren(slv_wren), .slv_strobe(slv_strobe), .slv_wait(slv_wait),
        .slv_rddata(slv_rddata), .protocol_err(protocol_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed vectors: own = 0 none, 1 master 0, 2 master 1 (selects expected slv_addr/wren).
    typedef struct {
        logic rst, s0, s1, l1, sw;
        logic e_ss; int own; logic e_w0, e_w1, e_perr;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, s0, s1, l1, sw, e_ss, input int own,
                       input logic e_w0, e_w1, e_perr);
        vec_t v;
        v.rst = rst; v.s0 = s0; v.s1 = s1; v.l1 = l1; v.sw = sw;
        v.e_ss = e_ss; v.own = own; v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_perr = e_perr;
        vt.push_back(v);
    endtask

    // Behavioural model: who holds the port (-1 nobody) and who was served last.
    int   owner;
    int   last_served;
    logic busy [2];

    function automatic int pick_next();
        if (m_strobe[0] && m_strobe[1]) return 1 - last_served;
        return m_strobe[0] ? 0 : 1;
    endfunction

    task automatic model_edge();
        if (reset) begin
            owner = -1; last_served = 1;
        end else if (owner < 0) begin
            if (m_strobe[0] || m_strobe[1]) begin
                owner = pick_next(); last_served = owner;
            end
        end else if (!m_strobe[owner]) begin
            owner = -1;
        end else if (!slv_wait && !m_lock[owner]) begin
            if (m_strobe[1 - owner]) begin
                owner = 1 - owner; last_served = owner;
            end else begin
                owner = -1;
            end
        end
    endtask

    task automatic model_check();
        logic e_ss, e_perr;
        logic e_w [2];
        e_ss   = (owner >= 0) ? m_strobe[owner] : 1'b0;
        e_perr = (owner >= 0) && !m_strobe[owner];
        for (int n = 0; n < 2; n++) e_w[n] = m_strobe[n] && !(owner == n && !slv_wait);
        chk("rnd_slv_strobe", 64'(slv_strobe), 64'(e_ss));
        chk("rnd_slv_addr",   64'(slv_addr),    (owner >= 0) ? 64'(m_addr[owner])    : 64'd0);
        chk("rnd_slv_wrdata", 64'(slv_wrdata),  (owner >= 0) ? 64'(m_wrdata[owner])  : 64'd0);
        chk("rnd_slv_bytesel",64'(slv_bytesel), (owner >= 0) ? 64'(m_bytesel[owner]) : 64'd0);
        chk("rnd_slv_wren",   64'(slv_wren),    (owner >= 0) ? 64'(m_wren[owner])    : 64'd0);
        chk("rnd_m0_wait", 64'(m0_wait), 64'(e_w[0]));
        chk("rnd_m1_wait", 64'(m1_wait), 64'(e_w[1]));
        chk("rnd_perr",    64'(protocol_err), 64'(e_perr));
        chk("rnd_rddata",  {m0_rddata, m1_rddata}, {slv_rddata, slv_rddata});
        for (int n = 0; n < 2; n++) if (m_strobe[n] && !e_w[n]) busy[n] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; slv_wait = 1'b0; slv_rddata = 32'hDEADBEEF;
        m_addr[0] = A0; m_wrdata[0] = 32'h1111_0000; m_bytesel[0] = 4'h3; m_wren[0] = 1'b0;
        m_addr[1] = A1; m_wrdata[1] = 32'h2222_0000; m_bytesel[1] = 4'hC; m_wren[1] = 1'b1;
        for (int n = 0; n < 2; n++) begin m_strobe[n] = 1'b0; m_lock[n] = 1'b0; end

        //   rst s0 s1 l1 sw | ss own w0 w1 perr
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);   // reset state
        add(0, 1, 0, 0, 1,   0, 0, 1, 0, 0);   // m0 read, arbitration cycle
        add(0, 1, 0, 0, 1,   1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1,   1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1,   1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0,   1, 1, 0, 0, 0);   // completion
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);   // reset restores last = 1
        add(0, 1, 1, 0, 0,   0, 0, 1, 1, 0);   // tie from reset
        add(0, 1, 1, 0, 0,   1, 1, 0, 1, 0);   // m0 first
        add(0, 0, 1, 0, 0,   1, 2, 0, 0, 0);   // m1 with no bubble
        add(0, 0, 1, 1, 0,   0, 0, 0, 1, 0);   // m1 alone, locked burst
        add(0, 1, 1, 1, 0,   1, 2, 1, 0, 0);
        add(0, 1, 1, 1, 0,   1, 2, 1, 0, 0);
        add(0, 1, 1, 1, 0,   1, 2, 1, 0, 0);
        add(0, 1, 1, 0, 0,   1, 2, 1, 0, 0);   // 4th, lock released
        add(0, 1, 0, 0, 0,   1, 1, 0, 0, 0);   // m0 on the 5th
        add(0, 0, 1, 0, 1,   0, 0, 0, 1, 0);   // abort scenario
        add(0, 1, 1, 0, 1,   1, 2, 1, 1, 0);
        add(0, 1, 0, 0, 1,   0, 2, 1, 0, 1);   // m1 drops strobe
        add(0, 1, 0, 0, 1,   0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1,   1, 1, 1, 0, 0);   // pending m0 granted
        add(0, 1, 0, 0, 0,   1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1,   0, 0, 0, 1, 0);   // reset mid-GNT1
        add(0, 0, 1, 0, 1,   1, 2, 0, 1, 0);
        add(1, 0, 1, 0, 1,   1, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1,   0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0,   1, 2, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

        repeat (2) tick();

        foreach (vt[i]) begin
            reset = vt[i].rst; m_strobe[0] = vt[i].s0; m_strobe[1] = vt[i].s1;
            m_lock[1] = vt[i].l1; slv_wait = vt[i].sw;
            @(negedge clk);
            chk($sformatf("vec%0d_slv_strobe", i), 64'(slv_strobe), 64'(vt[i].e_ss));
            chk($sformatf("vec%0d_slv_addr", i), 64'(slv_addr),
                (vt[i].own == 1) ? 64'(A0) : (vt[i].own == 2) ? 64'(A1) : 64'd0);
            chk($sformatf("vec%0d_slv_wren", i), 64'(slv_wren), (vt[i].own == 2) ? 64'd1 : 64'd0);
            chk($sformatf("vec%0d_m0_wait", i), 64'(m0_wait), 64'(vt[i].e_w0));
            chk($sformatf("vec%0d_m1_wait", i), 64'(m1_wait), 64'(vt[i].e_w1));
            chk($sformatf("vec%0d_perr", i), 64'(protocol_err), 64'(vt[i].e_perr));
            chk($sformatf("vec%0d_m0_rddata", i), 64'(m0_rddata), 64'h0000_0000_DEAD_BEEF);
            tick();
        end

        // Continuous contention: strict alternation starting with m0.
        reset = 1'b1; m_strobe[0] = 1'b0; m_strobe[1] = 1'b0; m_lock[1] = 1'b0; slv_wait = 1'b0;
        tick();
        reset = 1'b0; m_strobe[0] = 1'b1; m_strobe[1] = 1'b1;
        @(negedge clk);
        chk("alt_idle_strobe", 64'(slv_strobe), 64'd0);
        tick();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("alt%0d_addr", k), 64'(slv_addr), (k % 2 == 0) ? 64'(A0) : 64'(A1));
            chk($sformatf("alt%0d_waits", k), {63'd0, m0_wait} << 1 | 64'(m1_wait),
                (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
        end
        m_strobe[0] = 1'b0; m_strobe[1] = 1'b0;
        tick();

        // Randomized traffic against the model.
        reset = 1'b1; tick();
        owner = -1; last_served = 1; busy[0] = 1'b0; busy[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int n = 0; n < 2; n++) begin
                if (busy[n]) begin
                    if ($urandom_range(0, 39) == 0) begin
                        busy[n] = 1'b0; m_strobe[n] = 1'b0;
                    end else begin
                        m_strobe[n] = 1'b1;
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    busy[n] = 1'b1; m_strobe[n] = 1'b1;
                    m_addr[n]    = ADDR_W'($urandom);
                    m_wrdata[n]  = $urandom;
                    m_bytesel[n] = 4'($urandom);
                    m_wren[n]    = 1'($urandom);
                end else begin
                    m_strobe[n] = 1'b0;
                end
            end
            m_lock[0]  = ($urandom_range(0, 7) == 0);
            m_lock[1]  = ($urandom_range(0, 2) == 0);
            slv_wait   = 1'($urandom);
            slv_rddata = $urandom;
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
